// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: funct3 widths, fault causes, FSM states.
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [1:0] FC_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_GNT = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_DONE     = 2'd3
    } lsuState_t;

    function automatic logic f3Legal(input logic isStore, input logic [2:0] f3);
        if (isStore)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // f3[1:0] encodes the access size for every legal code
    function automatic logic isMisaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store enables/replicated data out, load lane select and extension in.
// Purely combinational, zero latency; carries no flow control of its own.
module lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]  stF3,
    input  logic [1:0]  stOff,
    input  logic [31:0] stData,
    output logic [3:0]  stBe,
    output logic [31:0] stWdata,
    input  logic [2:0]  ldF3,
    input  logic [1:0]  ldOff,
    input  logic [31:0] ldRaw,
    output logic [31:0] ldData
);

    logic [7:0]  ldByte;
    logic [15:0] ldHalf;

    always_comb begin
        stBe    = 4'b1111;
        stWdata = stData;
        case (stF3[1:0])
            2'b00: begin
                stBe    = 4'b0001 << stOff;
                stWdata = {4{stData[7:0]}};
            end
            2'b01: begin
                stBe    = stOff[1] ? 4'b1100 : 4'b0011;
                stWdata = {2{stData[15:0]}};
            end
            default: ;
        endcase
    end

    assign ldByte = ldRaw[{ldOff, 3'b000} +: 8];
    assign ldHalf = ldOff[1] ? ldRaw[31:16] : ldRaw[15:0];

    always_comb begin
        case (ldF3)
            F3_B:    ldData = {{24{ldByte[7]}}, ldByte};
            F3_H:    ldData = {{16{ldHalf[15]}}, ldHalf};
            F3_BU:   ldData = {24'd0, ldByte};
            F3_HU:   ldData = {16'd0, ldHalf};
            default: ldData = ldRaw;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid bus master with stall, alignment and timeout faults.
// Zero-wait load stalls 3 cycles, store 2; stall holds the pipeline while the bus withholds gnt/rvalid.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [2:0]  funct3,
    output logic [31:0] mem_rdata,
    output logic        stall,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    lsuState_t   state;
    logic [15:0] tmoCnt;
    logic        tmoHit;
    logic        isLoadQ;
    logic [2:0]  f3Q;
    logic [1:0]  offQ;
    logic [31:0] rdataQ;

    logic        access, legal, misaligned, startOk, badReq, tmoExpire;
    logic [3:0]  laneBe;
    logic [31:0] laneWdata, loadExt;

    assign access     = mem_we | mem_re;
    assign legal      = f3Legal(mem_we, funct3);
    assign misaligned = isMisaligned(funct3, mem_addr[1:0]);
    assign startOk    = access & legal & ~misaligned;
    assign badReq     = access & ~startOk;
    assign tmoExpire  = (tmoCnt == 16'(TIMEOUT_CYCLES - 1));

    lsu_align uAlign (
        .stF3    (funct3),
        .stOff   (mem_addr[1:0]),
        .stData  (mem_wdata),
        .stBe    (laneBe),
        .stWdata (laneWdata),
        .ldF3    (f3Q),
        .ldOff   (offQ),
        .ldRaw   (rdataQ),
        .ldData  (loadExt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            tmoCnt    <= '0;
            tmoHit    <= 1'b0;
            isLoadQ   <= 1'b0;
            f3Q       <= '0;
            offQ      <= '0;
            rdataQ    <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tmoCnt <= '0;
                    tmoHit <= 1'b0;
                    if (startOk) begin
                        bus_req   <= 1'b1;
                        bus_we    <= mem_we;
                        bus_addr  <= {mem_addr[31:2], 2'b00};
                        bus_be    <= laneBe;
                        bus_wdata <= mem_we ? laneWdata : '0;
                        isLoadQ   <= ~mem_we;
                        f3Q       <= funct3;
                        offQ      <= mem_addr[1:0];
                        rdataQ    <= '0;
                        state     <= S_WAIT_GNT;
                    end
                end
                S_WAIT_GNT: begin
                    tmoCnt <= tmoCnt + 16'd1;
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        state   <= isLoadQ ? S_WAIT_RSP : S_DONE;
                    end else if (tmoExpire) begin
                        bus_req <= 1'b0;
                        tmoHit  <= 1'b1;
                        if (isLoadQ)
                            rdataQ <= ERR_DATA;
                        state   <= S_DONE;
                    end
                end
                S_WAIT_RSP: begin
                    tmoCnt <= tmoCnt + 16'd1;
                    if (bus_rvalid) begin
                        rdataQ <= bus_rdata;
                        state  <= S_DONE;
                    end else if (tmoExpire) begin
                        tmoHit <= 1'b1;
                        rdataQ <= ERR_DATA;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    tmoCnt <= '0;
                    tmoHit <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Gated by reset so stall/fault drop the moment reset asserts, even with an access pending.
    always_comb begin
        stall       = 1'b0;
        fault       = 1'b0;
        fault_cause = 2'b00;
        mem_rdata   = '0;
        if (reset) begin
            case (state)
                S_IDLE: begin
                    stall = startOk;
                    fault = badReq;
                    if (badReq)
                        fault_cause = legal ? FC_MISALIGN : FC_ILLEGAL;
                end
                S_WAIT_GNT, S_WAIT_RSP: stall = 1'b1;
                S_DONE: begin
                    mem_rdata = loadExt;
                    fault     = tmoHit;
                    if (tmoHit)
                        fault_cause = FC_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed vector table, reset-abort sequence, then random transactions vs a model.
module tb_dmem_lsu;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re, stall, fault;
    logic [2:0]  funct3;
    logic [1:0]  fault_cause;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int nChk = 0;
    int nErr = 0;

    dmem_lsu #(.TIMEOUT_CYCLES(TMO), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .funct3(funct3), .mem_rdata(mem_rdata), .stall(stall), .fault(fault),
        .fault_cause(fault_cause), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus (we..rdata) plus expectations (stalls..wdExp).
    // stalls = cycles with stall high including the issuing cycle; 0 for faulting or no access.
    typedef struct {
        logic        we;
        logic        re;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gnt;
        int          rsp;
        logic [31:0] rdata;
        int          stalls;
        logic        bad;
        logic        tmo;
        logic [1:0]  cause;
        logic [31:0] dataExp;
        logic        chkBe;
        logic [3:0]  beExp;
        logic [31:0] wdExp;
    } txn_t;

    txn_t vec[16];

    task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
        end
    endtask

    function automatic logic [31:0] extend(input logic [2:0] f3, input int off, input logic [31:0] raw);
        logic [31:0] sh, b, h;
        sh = raw >> (8 * off);
        b  = sh & 32'hFF;
        h  = sh & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return raw;
        endcase
    endfunction

    function automatic txn_t predict(input txn_t s);
        txn_t t;
        int size, off, waits;
        logic legal;
        t     = s;
        size  = 1 << s.f3[1:0];
        off   = int'(s.addr % 32'd4);
        legal = s.we ? (s.f3 inside {3'd0, 3'd1, 3'd2}) : (s.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        t.bad = 1'b0; t.tmo = 1'b0; t.cause = 2'b00; t.dataExp = 32'd0; t.stalls = 0;
        t.chkBe = s.we || (size == 4);
        t.beExp = (size == 4) ? 4'hF : 4'(((size == 2) ? 3 : 1) << off);
        t.wdExp = (size == 1) ? (s.wdata & 32'hFF) * 32'h01010101 :
                  (size == 2) ? (s.wdata & 32'hFFFF) * 32'h00010001 : s.wdata;
        if (!(s.we || s.re)) return t;
        if (!legal || (off % size) != 0) begin
            t.bad   = 1'b1;
            t.cause = legal ? 2'b01 : 2'b11;
            return t;
        end
        waits = s.we ? s.gnt + 1 : s.gnt + 1 + s.rsp;
        if (waits <= TMO) begin
            t.stalls  = 1 + waits;
            t.dataExp = s.we ? 32'd0 : extend(s.f3, off, s.rdata);
        end else begin
            t.stalls  = 1 + TMO;
            t.tmo     = 1'b1;
            t.cause   = 2'b10;
            t.dataExp = s.we ? 32'd0 : extend(s.f3, off, 32'hDEADBEEF);
        end
        return t;
    endfunction

    task automatic noiseInputs();
        mem_we    = 1'($urandom_range(0, 1));
        mem_re    = 1'($urandom_range(0, 1));
        funct3    = 3'($urandom_range(0, 7));
        mem_addr  = $urandom;
        mem_wdata = $urandom;
    endtask

    // Entered and left one tick after a rising edge, with the DUT in IDLE.
    task automatic runTxn(input txn_t t, input string tag);
        mem_we = t.we; mem_re = t.re; funct3 = t.f3; mem_addr = t.addr; mem_wdata = t.wdata;
        bus_gnt = 1'b0; bus_rvalid = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
        @(negedge clk);
        chk(tag, "stall@issue", {31'd0, stall}, {31'd0, t.stalls > 0});
        chk(tag, "fault@issue", {31'd0, fault}, {31'd0, t.bad});
        if (t.bad) chk(tag, "cause@issue", {30'd0, fault_cause}, {30'd0, t.cause});
        chk(tag, "req@issue", {31'd0, bus_req}, 32'd0);
        chk(tag, "rdata@issue", mem_rdata, 32'd0);
        for (int k = 1; k < t.stalls; k++) begin
            @(posedge clk); #1;
            noiseInputs();
            bus_gnt = (k == t.gnt + 1);
            if (!t.we && k == t.gnt + 1 + t.rsp) begin
                bus_rvalid = 1'b1; bus_rdata = t.rdata;
            end else if (k <= t.gnt + 1) begin
                bus_rvalid = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
            end else begin
                bus_rvalid = 1'b0; bus_rdata = $urandom;
            end
            @(negedge clk);
            chk(tag, "stall@wait", {31'd0, stall}, 32'd1);
            chk(tag, "fault@wait", {31'd0, fault}, 32'd0);
            chk(tag, "req@wait", {31'd0, bus_req}, {31'd0, k <= t.gnt + 1});
            if (k <= t.gnt + 1) begin
                chk(tag, "bus_addr", bus_addr, t.addr & 32'hFFFF_FFFC);
                chk(tag, "bus_we", {31'd0, bus_we}, {31'd0, t.we});
                if (t.chkBe) chk(tag, "bus_be", {28'd0, bus_be}, {28'd0, t.beExp});
                if (t.we) chk(tag, "bus_wdata", bus_wdata, t.wdExp);
            end
        end
        if (t.stalls > 0) begin
            @(posedge clk); #1;
            noiseInputs();
            bus_gnt = 1'b0; bus_rvalid = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
            @(negedge clk);
            chk(tag, "stall@done", {31'd0, stall}, 32'd0);
            chk(tag, "fault@done", {31'd0, fault}, {31'd0, t.tmo});
            if (t.tmo) chk(tag, "cause@done", {30'd0, fault_cause}, {30'd0, t.cause});
            chk(tag, "mem_rdata", mem_rdata, t.dataExp);
            chk(tag, "req@done", {31'd0, bus_req}, 32'd0);
        end
        mem_we = 1'b0; mem_re = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        txn_t t;
        reset = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_we = 1'b0; mem_re = 1'b0; funct3 = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

        //          we    re    f3      addr          wdata          gnt  rsp  rdata         stl bad   tmo   cause  dataExp        chkBe be       wdExp
        vec[0]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h0,        0,   1,   32'h12345678, 3,  1'b0, 1'b0, 2'b00, 32'h12345678, 1'b1, 4'hF,    32'h0};
        vec[1]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0,        0,   1,   32'h80FFFFFF, 3,  1'b0, 1'b0, 2'b00, 32'hFFFFFF80, 1'b0, 4'h0,    32'h0};
        vec[2]  = '{1'b0, 1'b1, 3'b100, 32'h0000_0103, 32'h0,        0,   1,   32'h80FFFFFF, 3,  1'b0, 1'b0, 2'b00, 32'h00000080, 1'b0, 4'h0,    32'h0};
        vec[3]  = '{1'b0, 1'b1, 3'b101, 32'h0000_0102, 32'h0,        0,   1,   32'hBEEF0000, 3,  1'b0, 1'b0, 2'b00, 32'h0000BEEF, 1'b0, 4'h0,    32'h0};
        vec[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0000ABCD, 3,   0,   32'h0,        5,  1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 4'b1100, 32'hABCDABCD};
        vec[5]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0101, 32'h0,        0,   1,   32'h0,        0,  1'b1, 1'b0, 2'b01, 32'h0,        1'b0, 4'h0,    32'h0};
        vec[6]  = '{1'b0, 1'b1, 3'b011, 32'h0000_0100, 32'h0,        0,   1,   32'h0,        0,  1'b1, 1'b0, 2'b11, 32'h0,        1'b0, 4'h0,    32'h0};
        vec[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h0,        0,   100, 32'h0,        9,  1'b0, 1'b1, 2'b10, 32'hDEADBEEF, 1'b1, 4'hF,    32'h0};
        vec[8]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0301, 32'h000000A5, 0,   0,   32'h0,        2,  1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 4'b0010, 32'hA5A5A5A5};
        vec[9]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'hCAFEF00D, 1,   0,   32'h0,        3,  1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 4'hF,    32'hCAFEF00D};
        vec[10] = '{1'b0, 1'b1, 3'b001, 32'h0000_0106, 32'h0,        0,   1,   32'h80011234, 3,  1'b0, 1'b0, 2'b00, 32'hFFFF8001, 1'b0, 4'h0,    32'h0};
        vec[11] = '{1'b1, 1'b1, 3'b100, 32'h0000_0100, 32'h0,        0,   1,   32'h0,        0,  1'b1, 1'b0, 2'b11, 32'h0,        1'b0, 4'h0,    32'h0};
        vec[12] = '{1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        0,   1,   32'h0,        0,  1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 4'h0,    32'h0};
        vec[13] = '{1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h11223344, 100, 0,   32'h0,        9,  1'b0, 1'b1, 2'b10, 32'h0,        1'b1, 4'hF,    32'h11223344};
        vec[14] = '{1'b1, 1'b0, 3'b001, 32'h0000_0201, 32'h0000ABCD, 0,   0,   32'h0,        0,  1'b1, 1'b0, 2'b01, 32'h0,        1'b0, 4'h0,    32'h0};
        vec[15] = '{1'b1, 1'b0, 3'b001, 32'h0000_0200, 32'h12345678, 0,   0,   32'h0,        2,  1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 4'b0011, 32'h56785678};

        // Reset state, with a legal load presented so stall must still stay low
        #12;
        mem_re = 1'b1; funct3 = 3'b010; mem_addr = 32'h100;
        #1;
        chk("reset", "bus_req", {31'd0, bus_req}, 32'd0);
        chk("reset", "bus_we", {31'd0, bus_we}, 32'd0);
        chk("reset", "bus_addr", bus_addr, 32'd0);
        chk("reset", "bus_be", {28'd0, bus_be}, 32'd0);
        chk("reset", "bus_wdata", bus_wdata, 32'd0);
        chk("reset", "mem_rdata", mem_rdata, 32'd0);
        chk("reset", "stall", {31'd0, stall}, 32'd0);
        chk("reset", "fault", {31'd0, fault}, 32'd0);
        chk("reset", "fault_cause", {30'd0, fault_cause}, 32'd0);
        mem_re = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) runTxn(vec[i], $sformatf("vec%0d", i));

        // Reset asserted while waiting for the load response
        mem_re = 1'b1; mem_we = 1'b0; funct3 = 3'b010; mem_addr = 32'h104;
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        chk("midrst", "stall@rsp", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst", "bus_req", {31'd0, bus_req}, 32'd0);
        chk("midrst", "stall", {31'd0, stall}, 32'd0);
        chk("midrst", "fault", {31'd0, fault}, 32'd0);
        mem_re = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        t = vec[0];
        t.addr = 32'h104; t.rdata = 32'hA5C3_0F1E; t.dataExp = 32'hA5C3_0F1E;
        runTxn(t, "postrst");

        for (int i = 0; i < 120; i++) begin
            t.we    = 1'b0; t.re = 1'b0;
            case ($urandom_range(0, 2))
                0: t.re = 1'b1;
                1: t.we = 1'b1;
                default: begin t.we = 1'b1; t.re = 1'b1; end
            endcase
            t.f3    = 3'($urandom_range(0, 7));
            t.addr  = $urandom;
            t.wdata = $urandom;
            t.rdata = $urandom;
            t.gnt   = $urandom_range(0, 6);
            t.rsp   = $urandom_range(1, 4);
            t = predict(t);
            runTxn(t, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end

endmodule
